// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, fetch FSM states, reset vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: reset vector load, sequential +4 step and redirect load.
module pc_register
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Redirect wins over the sequential step; +4 wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: req/ack handshake to instruction memory, valid/ready
// handshake to decode, branch redirects, and a sticky fault on timeout or misalignment.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_fault
);

  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              redir_q, redir_d;
  logic [31:0]       redir_tgt_q, redir_tgt_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_out_q, pc_out_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [31:0] pc_s;
  logic        pc_inc_s;
  logic        pc_load_s;
  logic [31:0] pc_load_addr_s;
  logic        branch_bad_s;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clock       (clock),
    .reset_n     (reset_n),
    .inc_i       (pc_inc_s),
    .load_i      (pc_load_s),
    .load_addr_i (pc_load_addr_s),
    .pc_o        (pc_s)
  );

  assign branch_bad_s = branch_taken && !word_aligned(branch_target[1:0]);

  // Next-state, PC control and datapath capture.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    redir_d        = redir_q;
    redir_tgt_d    = redir_tgt_q;
    instr_d        = instr_q;
    pc_out_d       = pc_out_q;
    fault_d        = fault_q;
    pc_inc_s       = 1'b0;
    pc_load_s      = 1'b0;
    pc_load_addr_s = branch_target;

    case (state_q)
      FETCH_IDLE: begin
        if (branch_bad_s) begin
          state_d = FETCH_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d   = FETCH_REQ;
          pc_load_s = branch_taken;
        end
      end
      FETCH_REQ: begin
        if (branch_bad_s) begin
          state_d = FETCH_FAULT;
          fault_d = 1'b1;
          wait_d  = '0;
        end else if (imem_ack) begin
          wait_d = '0;
          // A pending or same-cycle redirect drops the returned word and refetches.
          if (branch_taken || redir_q) begin
            pc_load_s      = 1'b1;
            pc_load_addr_s = branch_taken ? branch_target : redir_tgt_q;
            redir_d        = 1'b0;
            state_d        = FETCH_REQ;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_s;
            state_d  = FETCH_HOLD;
          end
        end else begin
          if (branch_taken) begin
            redir_d     = 1'b1;
            redir_tgt_d = branch_target;
          end else begin
            redir_d     = redir_q;
            redir_tgt_d = redir_tgt_q;
          end
          if (wait_q == WAIT_LAST) begin
            state_d = FETCH_FAULT;
            fault_d = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      FETCH_HOLD: begin
        if (branch_bad_s) begin
          state_d = FETCH_FAULT;
          fault_d = 1'b1;
        end else if (branch_taken) begin
          pc_load_s = 1'b1;
          state_d   = FETCH_REQ;
        end else if (instr_ready) begin
          pc_inc_s = 1'b1;
          state_d  = FETCH_REQ;
        end else begin
          state_d = FETCH_HOLD;
        end
      end
      FETCH_FAULT: begin
        state_d = FETCH_FAULT;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    req_d   = (state_d == FETCH_REQ);
    valid_d = (state_d == FETCH_HOLD);
  end

  // FSM and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH_IDLE;
      wait_q      <= '0;
      redir_q     <= 1'b0;
      redir_tgt_q <= 32'h0000_0000;
      instr_q     <= 32'h0000_0000;
      pc_out_q    <= 32'h0000_0000;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      redir_q     <= redir_d;
      redir_tgt_q <= redir_tgt_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_s;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios push expected fetch
// addresses and instructions; a negedge monitor pops and compares.
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4;
  logic [5:0]  op;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;

  logic        reset_w_n = 1'b0;
  logic        w_req, w_valid, w_fault;
  logic [31:0] w_addr, w_instr, w_pc_out, w_pc_plus4;
  logic [5:0]  w_op;
  logic        ack_w = 1'b0;
  logic [31:0] rdata_w = 32'h0;
  logic        ready_w = 1'b0;

  int checks = 0;
  int errors = 0;
  int present_cnt = 0;
  int cyc = 0;
  int req_cyc[$];
  logic [31:0] exp_addr_q[$];
  exp_t exp_ins_q[$];
  exp_t cur_exp;
  logic prev_req = 1'b0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int ack_delay = 0;
  bit ack_en = 1'b1;
  bit force_ack = 1'b0;
  int mem_wait = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .op(op), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clock(clock), .reset_n(reset_w_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .instr_valid(w_valid),
    .instr_ready(ready_w), .instr(w_instr), .op(w_op), .pc_out(w_pc_out),
    .pc_plus4(w_pc_plus4), .branch_taken(1'b0), .branch_target(32'h0000_0000),
    .fetch_fault(w_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h0000_000C) w = 32'h8C01_0004;
    else w = {a[7:2], 26'h0123456};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Memory responder: acks after ack_delay wait cycles while a request is up.
  initial begin
    forever begin
      @(negedge clock);
      if (force_ack) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        mem_wait = 0;
      end else if (imem_req && ack_en) begin
        if (mem_wait >= ack_delay) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          mem_wait = 0;
        end else begin
          imem_ack = 1'b0;
          mem_wait++;
        end
      end else begin
        imem_ack = 1'b0;
        mem_wait = 0;
      end
    end
  end

  // Monitor: new requests pop the address queue, new presentations pop the instruction queue.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        prev_req = 1'b0;
        prev_valid = 1'b0;
        prev_addr = 32'h0;
      end else begin
        if (imem_req && (!prev_req || imem_addr != prev_addr)) begin
          req_cyc.push_back(cyc);
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: actual addr %h required no request", imem_addr);
          end else begin
            chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
          end
        end
        if (instr_valid && !prev_valid) begin
          present_cnt++;
          if (exp_ins_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: actual %h required no instruction", instr);
          end else begin
            cur_exp = exp_ins_q.pop_front();
            chk("instr", instr, cur_exp.ins);
            chk("op", 32'(op), 32'(cur_exp.ins[31:26]));
            chk("pc_out", pc_out, cur_exp.pc);
            chk("pc_plus4", pc_plus4, cur_exp.pc + 32'd4);
          end
        end else if (instr_valid) begin
          chk("instr_hold", instr, cur_exp.ins);
          chk("pc_out_hold", pc_out, cur_exp.pc);
        end
        prev_req = imem_req;
        prev_valid = instr_valid;
        prev_addr = imem_addr;
      end
    end
  end

  task automatic push_fetch(input logic [31:0] a, input bit presented);
    exp_t e;
    exp_addr_q.push_back(a);
    if (presented) begin
      e.pc = a;
      e.ins = (a == 32'h0000_000C) ? 32'h8C01_0004 : {a[7:2], 26'h0123456};
      exp_ins_q.push_back(e);
    end
  endtask

  task automatic wait_present(input int target, input string name);
    int n = 0;
    while (present_cnt < target && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(present_cnt), 32'(target));
  endtask

  task automatic reset_checks();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    #1;
    reset_checks();
    chk("drain_addr", 32'(exp_addr_q.size()), 32'd0);
    chk("drain_instr", 32'(exp_ins_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_ins_q.delete();
    step();
    step();
    req_cyc.delete();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int reqs;
    bit any_req;

    // Reset vector at the top of the address space wraps to 0 on the second fetch.
    step();
    chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("w_rst_req", 32'(w_req), 32'd0);
    reset_w_n = 1'b1;
    step();
    chk("w_req1", 32'(w_req), 32'd1);
    chk("w_addr1", w_addr, 32'hFFFF_FFFC);
    ack_w = 1'b1;
    rdata_w = 32'hFC12_3456;
    ready_w = 1'b1;
    step();
    ack_w = 1'b0;
    chk("w_valid", 32'(w_valid), 32'd1);
    chk("w_instr", w_instr, 32'hFC12_3456);
    chk("w_pc_out", w_pc_out, 32'hFFFF_FFFC);
    chk("w_pc_plus4", w_pc_plus4, 32'h0000_0000);
    step();
    chk("w_req2", 32'(w_req), 32'd1);
    chk("w_addr2", w_addr, 32'h0000_0000);
    chk("w_fault", 32'(w_fault), 32'd0);
    reset_w_n = 1'b0;

    // Streaming: ack with req, ready always high, one instruction per two cycles.
    do_reset();
    ack_delay = 0;
    instr_ready = 1'b1;
    base = present_cnt;
    push_fetch(32'h0, 1'b1);
    push_fetch(32'h4, 1'b1);
    push_fetch(32'h8, 1'b1);
    wait_present(base + 3, "stream_count");
    instr_ready = 1'b0;
    chk("stream_reqs", 32'(req_cyc.size()), 32'd3);
    if (req_cyc.size() >= 3) begin
      chk("stream_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
      chk("stream_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
    end

    // Branch in IDLE to a LW word, then back-pressure for five cycles.
    do_reset();
    branch_taken = 1'b1;
    branch_target = 32'h0000_000C;
    base = present_cnt;
    push_fetch(32'h0000_000C, 1'b1);
    step();
    branch_taken = 1'b0;
    wait_present(base + 1, "lw_present");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lw_valid_held", 32'(instr_valid), 32'd1);
      chk("lw_op", 32'(op), 32'd35);
      chk("lw_pc_out", pc_out, 32'h0000_000C);
    end
    push_fetch(32'h0000_0010, 1'b1);
    instr_ready = 1'b1;
    wait_present(base + 2, "lw_next");
    instr_ready = 1'b0;

    // Two branches during a slow REQ: last target wins, returned word dropped.
    do_reset();
    ack_delay = 3;
    instr_ready = 1'b1;
    base = present_cnt;
    push_fetch(32'h0, 1'b0);
    push_fetch(32'h40, 1'b1);
    step();
    branch_taken = 1'b1;
    branch_target = 32'h80;
    step();
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    wait_present(base + 1, "redir_present");
    instr_ready = 1'b0;
    ack_delay = 0;

    // Branch and ready together in HOLD: branch wins.
    do_reset();
    instr_ready = 1'b1;
    base = present_cnt;
    push_fetch(32'h0, 1'b1);
    push_fetch(32'h100, 1'b1);
    wait_present(base + 1, "hold_first");
    branch_taken = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    wait_present(base + 2, "hold_branch");
    instr_ready = 1'b0;

    // Ack never arrives: fault after 15 request cycles, then terminal.
    do_reset();
    ack_en = 1'b0;
    push_fetch(32'h0, 1'b0);
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fetch_fault) break;
      if (imem_req) reqs++;
    end
    chk("timeout_cycles", 32'(reqs), 32'd15);
    chk("timeout_fault", 32'(fetch_fault), 32'd1);
    ack_en = 1'b1;
    instr_ready = 1'b1;
    repeat (5) step();
    chk("fault_req", 32'(imem_req), 32'd0);
    chk("fault_valid", 32'(instr_valid), 32'd0);
    chk("fault_sticky", 32'(fetch_fault), 32'd1);

    // Misaligned target: fault with no request issued.
    do_reset();
    instr_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h102;
    step();
    branch_taken = 1'b0;
    chk("misalign_fault", 32'(fetch_fault), 32'd1);
    any_req = imem_req;
    repeat (4) begin
      step();
      any_req = any_req | imem_req;
    end
    chk("misalign_no_req", 32'(any_req), 32'd0);

    // Reset mid-REQ drops the request; a late ack in IDLE is ignored.
    do_reset();
    ack_delay = 5;
    instr_ready = 1'b1;
    base = present_cnt;
    push_fetch(32'h0, 1'b0);
    step();
    step();
    chk("midreq_req", 32'(imem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midreq_drop", 32'(imem_req), 32'd0);
    reset_checks();
    step();
    force_ack = 1'b1;
    step();
    reset_n = 1'b1;
    force_ack = 1'b0;
    ack_delay = 0;
    push_fetch(32'h0, 1'b1);
    wait_present(base + 1, "late_ack_present");
    instr_ready = 1'b0;
    step();

    chk("final_drain_addr", 32'(exp_addr_q.size()), 32'd0);
    chk("final_drain_instr", 32'(exp_ins_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
